cp0_reg: RTL
============

# cp0_reg

Coprocessor-0 register file for the five-stage MIPS core. It holds Count, Compare, Status, Cause, EPC, PRId and Config, and serves mfc0 reads and mtc0 writes. It commits the architectural side effects of every exception code the pipeline controller acts on, updating EPC, Cause.ExcCode, Cause.BD and Status.EXL. It drives the EPC value the controller uses as the eret target, and it raises the Count/Compare timer interrupt.

## Interface
Parameters:
- PRID_VALUE, 32'h004c0102, reset and constant value of PRId (reg 15)
- CONFIG_VALUE, 32'h00008000, reset value of Config (reg 16, big-endian bit set)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (`RstEnable` = 1)
- we_i  in  1  mtc0 write enable (from WB stage)
- waddr_i  in  5  CP0 register number written
- data_i  in  32  write data
- raddr_i  in  5  CP0 register number read
- int_i  in  6  external hardware interrupt lines, level-sensitive
- excepttype_i  in  32  exception code from MEM stage; same encoding the controller decodes
- current_inst_addr_i  in  32  PC of the excepting instruction
- is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot
- data_o  out  32  read data for raddr_i
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  register values
- timer_int_o  out  1  timer interrupt; routed externally to int_i[5]

## Operation
- Reset values: count 0, compare 0, status 32'h10000000 (CU0=1), cause 0, epc 0, config CONFIG_VALUE, prid PRID_VALUE, timer_int_o 0, data_o 0.
- Count increments by 1 every non-reset cycle and wraps at 32'hFFFFFFFF→0. An mtc0 to reg 9 loads data_i and replaces the increment in that cycle.
- Compare (reg 11) is fully writable. Writing it clears timer_int_o.
- Status (reg 12) is fully writable.
- Cause (reg 13): only IP[1:0] (bits 9:8), WP (bit 22) and IV (bit 23) are writable by mtc0. IP[7:2] (bits 15:10) are loaded from int_i every cycle. ExcCode (bits 6:2) and BD (bit 31) are written only by exceptions.
- EPC (reg 14) is fully writable.
- PRId and Config writes are ignored.
- Writes to unlisted numbers are ignored. Reads of unlisted numbers return 0.
- Exception commit, applied at the clock edge for a nonzero excepttype_i:
  - Common path for 0x01, 0x08, 0x0a, 0x0d, 0x0c:
    - If Status.EXL==0: EPC ← current_inst_addr_i − 4 and BD ← 1 when is_in_delayslot_i, else EPC ← current_inst_addr_i and BD ← 0.
    - If Status.EXL==1: EPC and BD are unchanged.
    - Then EXL ← 1.
  - ExcCode per code:
    - 0x01 interrupt → 5'h00
    - 0x08 syscall → 5'h08
    - 0x0a invalid instruction → 5'h0a
    - 0x0d trap → 5'h0d
    - 0x0c overflow → 5'h0c
  - 0x0e eret: EXL ← 0. No other change.
  - Any other nonzero code: no change.
- Simultaneous mtc0 and exception: the mtc0 is applied first and the exception fields override it. Fields the exception does not touch keep the mtc0 value.
- Reset has priority over everything. An assertion mid-operation restores all reset values at that edge.

## Timing
- data_o and all register outputs are combinational from current register state; there is no write-to-read bypass.
- An mtc0 becomes visible on data_o and the register outputs one cycle after the we_i edge.
- epc_o reflects an exception commit on the cycle after excepttype_i is presented. The controller's eret path uses the pre-commit epc_o, which is stable.
- Timer match is registered. When count==compare and compare!=0 at an edge, timer_int_o goes 1 at that edge, is sticky, and clears only on a Compare write or reset. A Compare write in the match cycle wins, and timer_int_o stays 0.
- Cause.IP tracks int_i with one cycle latency.

## Configuration
- CP0_TIMER_INT_EN defined: Count/Compare match logic is present and behaves as above.
- CP0_TIMER_INT_EN undefined: timer_int_o is tied 0 and the match comparator is removed. Count still increments, and Compare remains readable/writable.

## Test plan
- Reset, then read regs 9,11,12,13,14,15,16 → 0, 0, 32'h10000000, 0, 0, 32'h004c0102, 32'h00008000. Count reads 5 after 5 cycles.
- mtc0 cause ← 32'hFFFFFFFF with int_i=6'b000001 → cause reads 32'h00C00700 (IV, WP, IP1:0, IP2).
- syscall (0x08) at PC 32'h00000100, not in delay slot → epc 32'h00000100, ExcCode 8, EXL 1. A second syscall at 32'h200 leaves epc at 32'h100. eret then clears EXL.
- overflow (0x0c) at PC 32'h00000204 in delay slot, together with mtc0 epc←32'hDEAD → epc 32'h00000200, BD 1, ExcCode 12.
- mtc0 compare←10, mtc0 count←5 → timer_int_o rises after count reaches 10 and holds. mtc0 compare←100 → drops next cycle. With the macro undefined, timer_int_o stays 0 throughout.
- Reset asserted the cycle after an exception commit → all registers return to reset values.

Source files
------------

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Count/Compare/Status/Cause/EPC/PRId/Config, mtc0/mfc0, exception commit.
// Optional Count/Compare timer interrupt is enabled by defining CP0_TIMER_INT_EN.
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

  localparam logic [31:0] STATUS_RST = 32'h10000000;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        timer_q, timer_d;

  logic        exc_common;
  logic [4:0]  exc_code;
  logic        compare_wr;

  assign compare_wr = we_i && (waddr_i == REG_COMPARE);

  always_comb begin
    exc_common = 1'b1;
    exc_code   = 5'h00;
    case (excepttype_i)
      32'h0000_0001: exc_code = 5'h00;
      32'h0000_0008: exc_code = 5'h08;
      32'h0000_000a: exc_code = 5'h0a;
      32'h0000_000d: exc_code = 5'h0d;
      32'h0000_000c: exc_code = 5'h0c;
      default:       exc_common = 1'b0;
    endcase
  end

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    cause_d[15:10] = int_i;

    if (we_i) begin
      case (waddr_i)
        REG_COUNT:   count_d   = data_i;
        REG_COMPARE: compare_d = data_i;
        REG_STATUS:  status_d  = data_i;
        REG_EPC:     epc_d     = data_i;
        REG_CAUSE: begin
          cause_d[9:8]   = data_i[9:8];
          cause_d[23:22] = data_i[23:22];
        end
        default: ;
      endcase
    end

    // Exception fields are applied after the mtc0 so they override it.
    if (exc_common) begin
      if (!status_q[1]) begin
        if (is_in_delayslot_i) begin
          epc_d       = current_inst_addr_i - 32'd4;
          cause_d[31] = 1'b1;
        end else begin
          epc_d       = current_inst_addr_i;
          cause_d[31] = 1'b0;
        end
      end
      status_d[1]   = 1'b1;
      cause_d[6:2]  = exc_code;
    end else if (excepttype_i == 32'h0000_000e) begin
      status_d[1] = 1'b0;
    end
  end

`ifdef CP0_TIMER_INT_EN
  always_comb begin
    timer_d = timer_q;
    if (compare_wr)
      timer_d = 1'b0;
    else if ((count_q == compare_q) && (compare_q != 32'd0))
      timer_d = 1'b1;
  end
`else
  assign timer_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      status_q  <= STATUS_RST;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    data_o = 32'd0;
    if (!rst) begin
      case (raddr_i)
        REG_COUNT:   data_o = count_q;
        REG_COMPARE: data_o = compare_q;
        REG_STATUS:  data_o = status_q;
        REG_CAUSE:   data_o = cause_q;
        REG_EPC:     data_o = epc_q;
        REG_PRID:    data_o = PRID_VALUE;
        REG_CONFIG:  data_o = CONFIG_VALUE;
        default:     data_o = 32'd0;
      endcase
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign config_o    = CONFIG_VALUE;
  assign prid_o      = PRID_VALUE;
  assign timer_int_o = timer_q;

endmodule
